// File: rtl/tlul_adapter_reg_mo_if.sv
// TL-UL port bundle for tlul_adapter_reg_mo: packed A-channel/d_ready request word
// and packed D-channel/a_ready response word.
interface tlul_adapter_reg_mo_if;
  logic [101:0] tl_i;
  logic [67:0]  tl_o;

  modport master (output tl_i, input tl_o);
  modport slave  (input tl_i, output tl_o);
endinterface

// File: rtl/tlul_adapter_reg_mo.sv
// TL-UL to register-interface adapter with a response FIFO that lets several requests be in flight.
// Optional build macro TLUL_ADAPTER_REG_BUSY_EN adds busy_i back-pressure from the register block.
module tlul_adapter_reg_mo #(
  parameter int RegAw       = 8,
  parameter int RegDw       = 32,
  parameter int Outstanding = 2,
  parameter int RdLatency   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tlul_adapter_reg_mo_if.slave tl,
  output logic                 re_o,
  output logic                 we_o,
  output logic [RegAw-1:0]     addr_o,
  output logic [RegDw-1:0]     wdata_o,
  output logic [RegDw/8-1:0]   be_o,
  input  logic [RegDw-1:0]     rdata_i,
  input  logic                 error_i
`ifdef TLUL_ADAPTER_REG_BUSY_EN
  ,
  input  logic                 busy_i
`endif
);

  localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int CntW = $clog2(Outstanding + 1);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } rsp_t;

  // Malformed-request check: unsupported opcode/size, partial PutFull, unaligned write, user[8].
  function automatic logic req_err(input logic [2:0] op, input logic [1:0] size,
                                   input logic [3:0] mask, input logic [1:0] addr_lo,
                                   input logic user8);
    logic op_ok;
    logic is_wr;
    op_ok = (op == 3'd4) || (op == 3'd0) || (op == 3'd1);
    is_wr = (op == 3'd0) || (op == 3'd1);
    return !op_ok || (size > 2'd2) || ((op == 3'd0) && (mask != 4'hF)) ||
           (is_wr && (addr_lo != 2'b00)) || user8;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Outstanding - 1)) begin
      return '0;
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  logic        a_valid, d_ready;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [7:0]  a_source;
  logic [31:0] a_address, a_data;
  logic [3:0]  a_mask;
  logic [15:0] a_user;

  assign a_valid   = tl.tl_i[101];
  assign a_opcode  = tl.tl_i[100:98];
  assign a_size    = tl.tl_i[94:93];
  assign a_source  = tl.tl_i[92:85];
  assign a_address = tl.tl_i[84:53];
  assign a_mask    = tl.tl_i[52:49];
  assign a_data    = tl.tl_i[48:17];
  assign a_user    = tl.tl_i[16:1];
  assign d_ready   = tl.tl_i[0];

  logic unused_tl_s;
  assign unused_tl_s = ^{tl.tl_i[97:95], a_address[31:RegAw], a_user[15:9], a_user[7:0]};

  rsp_t            mem_q [Outstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            pend_q;
  logic [1:0]      pend_size_q;
  logic [7:0]      pend_source_q;

  logic [CntW:0] occ;
  logic          a_ready, a_ack, is_get, is_wr, err_int;
  logic          new_pend, new_push, d_valid, pop;
  logic [1:0]    n_push;
  rsp_t          new_entry, pend_entry, entry0, entry1, head;

  assign occ = {1'b0, count_q} + (CntW + 1)'(pend_q);
`ifdef TLUL_ADAPTER_REG_BUSY_EN
  assign a_ready = (occ < (CntW + 1)'(Outstanding)) && !busy_i;
`else
  assign a_ready = (occ < (CntW + 1)'(Outstanding));
`endif

  assign is_get  = (a_opcode == 3'd4);
  assign is_wr   = (a_opcode == 3'd0) || (a_opcode == 3'd1);
  assign err_int = req_err(a_opcode, a_size, a_mask, a_address[1:0], a_user[8]);
  assign a_ack   = a_valid && a_ready;

  assign re_o    = a_ack && is_get && !err_int;
  assign we_o    = a_ack && is_wr && !err_int;
  assign addr_o  = {a_address[RegAw-1:2], 2'b00};
  assign wdata_o = a_data[RegDw-1:0];
  assign be_o    = a_mask[RegDw/8-1:0];

  // A good read with registered read data waits one cycle in the pend slot.
  assign new_pend = (RdLatency == 1) && re_o;
  assign new_push = a_ack && !new_pend;

  // Response entry for a request completing in its own acceptance cycle.
  always_comb begin
    new_entry        = '0;
    new_entry.opcode = is_get ? 3'd1 : 3'd0;
    new_entry.size   = a_size;
    new_entry.source = a_source;
    new_entry.error  = err_int || error_i;
    if (is_wr) begin
      new_entry.data = 32'h0000_0000;
    end else if (err_int) begin
      new_entry.data = 32'hFFFF_FFFF;
    end else begin
      new_entry.data = rdata_i;
    end
  end

  // Deferred read entry built from the held meta and this cycle's read data.
  always_comb begin
    pend_entry        = '0;
    pend_entry.opcode = 3'd1;
    pend_entry.size   = pend_size_q;
    pend_entry.source = pend_source_q;
    pend_entry.data   = rdata_i;
    pend_entry.error  = error_i;
  end

  // The pend entry is older than any new request, so it takes the first write slot.
  always_comb begin
    entry0 = '0;
    entry1 = '0;
    n_push = 2'd0;
    if (pend_q) begin
      entry0 = pend_entry;
      entry1 = new_entry;
      n_push = new_push ? 2'd2 : 2'd1;
    end else begin
      entry0 = new_entry;
      n_push = new_push ? 2'd1 : 2'd0;
    end
  end

  assign d_valid = (count_q != '0);
  assign pop     = d_valid && d_ready;
  assign head    = d_valid ? mem_q[rd_ptr_q] : '0;

  assign tl.tl_o = {d_valid, head.opcode, 3'b000, head.size, head.source, 1'b0,
                    head.data, 16'h0000, head.error, a_ready};

  // Response FIFO storage and pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Outstanding; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      case (n_push)
        2'd1: begin
          mem_q[wr_ptr_q] <= entry0;
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        2'd2: begin
          mem_q[wr_ptr_q]          <= entry0;
          mem_q[ptr_inc(wr_ptr_q)] <= entry1;
          wr_ptr_q                 <= ptr_inc(ptr_inc(wr_ptr_q));
        end
        default: wr_ptr_q <= wr_ptr_q;
      endcase
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CntW'(n_push) - CntW'(pop);
    end
  end

  // Pending registered-read slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q        <= 1'b0;
      pend_size_q   <= 2'b00;
      pend_source_q <= 8'h00;
    end else begin
      pend_q <= new_pend;
      if (new_pend) begin
        pend_size_q   <= a_size;
        pend_source_q <= a_source;
      end
    end
  end

endmodule
